// File: rtl/paint_job_arbiter_if.sv
// Requester and drawing-engine signal bundle for paint_job_arbiter.
// The arbiter takes the slave view; paint sequencers and the engine model take the master view.
interface paint_job_arbiter_if #(
    parameter int NUM_REQ         = 4,
    parameter int GRANT_BITS      = 2,
    parameter int SCR_WIDTH_BITS  = 8,
    parameter int SCR_HEIGHT_BITS = 7,
    parameter int COLOR_SIZE      = 3
);
    localparam int DESC_W = 2*SCR_WIDTH_BITS + 2*SCR_HEIGHT_BITS + COLOR_SIZE + 3;

    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*DESC_W-1:0]  req_desc;
    logic [NUM_REQ-1:0]         req_ack;
    logic [NUM_REQ-1:0]         req_done;
    logic [NUM_REQ-1:0]         req_err;
    logic                       eng_start;
    logic [SCR_WIDTH_BITS-1:0]  eng_x_start;
    logic [SCR_WIDTH_BITS-1:0]  eng_x_end;
    logic [SCR_HEIGHT_BITS-1:0] eng_y_start;
    logic [SCR_HEIGHT_BITS-1:0] eng_y_end;
    logic [COLOR_SIZE-1:0]      eng_color;
    logic [2:0]                 eng_config;
    logic                       eng_done;
    logic                       busy;
    logic [GRANT_BITS-1:0]      cur_grant;

    modport slave (
        input  req, req_desc, eng_done,
        output req_ack, req_done, req_err, eng_start, eng_x_start, eng_x_end,
               eng_y_start, eng_y_end, eng_color, eng_config, busy, cur_grant
    );

    modport master (
        output req, req_desc, eng_done,
        input  req_ack, req_done, req_err, eng_start, eng_x_start, eng_x_end,
               eng_y_start, eng_y_end, eng_color, eng_config, busy, cur_grant
    );
endinterface

// File: rtl/paint_job_arbiter.sv
// Round-robin arbiter sharing one shape-fill engine among NUM_REQ paint requesters.
// Latches the winner's job, pulses eng_start, waits for eng_done or timeout, returns done/err.
module paint_job_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int GRANT_BITS      = 2,
    parameter int SCR_WIDTH_BITS  = 8,
    parameter int SCR_HEIGHT_BITS = 7,
    parameter int COLOR_SIZE      = 3,
    parameter int TIMEOUT         = 65535
) (
    input logic Clck,
    input logic Reset,
    paint_job_arbiter_if.slave bus
);
    localparam int DESC_W = 2*SCR_WIDTH_BITS + 2*SCR_HEIGHT_BITS + COLOR_SIZE + 3;
    localparam int COL_LO = 3;
    localparam int YE_LO  = COL_LO + COLOR_SIZE;
    localparam int YS_LO  = YE_LO + SCR_HEIGHT_BITS;
    localparam int XE_LO  = YS_LO + SCR_HEIGHT_BITS;
    localparam int XS_LO  = XE_LO + SCR_WIDTH_BITS;
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DONE} state_t;

    state_t                     r_state;
    logic [GRANT_BITS-1:0]      r_grant;
    logic [GRANT_BITS-1:0]      r_last;
    logic [15:0]                r_cnt;
    logic [NUM_REQ-1:0]         r_ack;
    logic [NUM_REQ-1:0]         r_done;
    logic [NUM_REQ-1:0]         r_err;
    logic                       r_start;
    logic [SCR_WIDTH_BITS-1:0]  r_x_start;
    logic [SCR_WIDTH_BITS-1:0]  r_x_end;
    logic [SCR_HEIGHT_BITS-1:0] r_y_start;
    logic [SCR_HEIGHT_BITS-1:0] r_y_end;
    logic [COLOR_SIZE-1:0]      r_color;
    logic [2:0]                 r_config;

    logic                       w_found;
    logic [GRANT_BITS-1:0]      w_winner;
    logic [DESC_W-1:0]          w_desc;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [GRANT_BITS-1:0] g);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int idx;
            idx = (int'(r_last) + i) % NUM_REQ;
            if (!w_found && bus.req[idx]) begin
                w_found  = 1'b1;
                w_winner = GRANT_BITS'(idx);
            end
        end
    end

    assign w_desc = bus.req_desc[int'(w_winner)*DESC_W +: DESC_W];

    always_ff @(posedge Clck) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_last    <= GRANT_BITS'(NUM_REQ-1);
            r_cnt     <= '0;
            r_ack     <= '0;
            r_done    <= '0;
            r_err     <= '0;
            r_start   <= 1'b0;
            r_x_start <= '0;
            r_x_end   <= '0;
            r_y_start <= '0;
            r_y_end   <= '0;
            r_color   <= '0;
            r_config  <= '0;
        end else begin
            r_ack   <= '0;
            r_done  <= '0;
            r_err   <= '0;
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant   <= w_winner;
                        r_last    <= w_winner;
                        r_x_start <= w_desc[XS_LO +: SCR_WIDTH_BITS];
                        r_x_end   <= w_desc[XE_LO +: SCR_WIDTH_BITS];
                        r_y_start <= w_desc[YS_LO +: SCR_HEIGHT_BITS];
                        r_y_end   <= w_desc[YE_LO +: SCR_HEIGHT_BITS];
                        r_color   <= w_desc[COL_LO +: COLOR_SIZE];
                        r_config  <= w_desc[2:0];
                        r_ack     <= onehot(w_winner);
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Empty or inverted rectangles are rejected without touching the engine.
                    if (r_x_end <= r_x_start || r_y_end <= r_y_start) begin
                        r_done  <= onehot(r_grant);
                        r_err   <= onehot(r_grant);
                        r_state <= S_DONE;
                    end else begin
                        r_start <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_cnt   <= TIMEOUT_C;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // eng_done takes priority over an expiring counter.
                    if (bus.eng_done) begin
                        r_done  <= onehot(r_grant);
                        r_state <= S_DONE;
                    end else if (r_cnt == 16'd0) begin
                        r_done  <= onehot(r_grant);
                        r_err   <= onehot(r_grant);
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ack     = r_ack;
    assign bus.req_done    = r_done;
    assign bus.req_err     = r_err;
    assign bus.eng_start   = r_start;
    assign bus.eng_x_start = r_x_start;
    assign bus.eng_x_end   = r_x_end;
    assign bus.eng_y_start = r_y_start;
    assign bus.eng_y_end   = r_y_end;
    assign bus.eng_color   = r_color;
    assign bus.eng_config  = r_config;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.cur_grant   = r_grant;
endmodule
